// File: rtl/bcd_timer_pkg.sv
// rtl/bcd_timer_pkg.sv - shared state encoding and BCD helpers for bcd_timer_ctrl
package bcd_timer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    DONE  = 3'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_timer_ctrl_if.sv
// rtl/bcd_timer_ctrl_if.sv - front-panel control and display-side bundle of bcd_timer_ctrl
interface bcd_timer_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  pause;
  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  mode;
  logic [4*DIGITS-1:0]   q;
  logic                  busy;
  logic                  done;
  logic [2:0]            state;

  modport master (
    output start, pause, clear, load, load_val, mode,
    input  q, busy, done, state
  );

  modport slave (
    input  start, pause, clear, load, load_val, mode,
    output q, busy, done, state
  );
endinterface

// File: rtl/bcd_digit_ld.sv
// rtl/bcd_digit_ld.sv - one cascadable BCD up/down digit with synchronous load
module bcd_digit_ld
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  input  logic       up,
  output logic [3:0] d,
  output logic       term
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d <= BCD_MIN;
    end else if (load) begin
      d <= load_val;
    end else if (en) begin
      if (up) d <= (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
      else    d <= (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
    end
  end

  assign term = up ? (d == BCD_MAX) : (d == BCD_MIN);

endmodule

// File: rtl/bcd_timer_ctrl.sv
// rtl/bcd_timer_ctrl.sv - BCD timer sequencer: prescaler, cascade enables, run/pause/done FSM
// Optional auto-reload on terminal value: BCD_TIMER_AUTO_RELOAD_EN
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 1000
) (
  input  logic            clk,
  input  logic            rstn,
  bcd_timer_ctrl_if.slave bus
);

  localparam int            W         = 4 * DIGITS;
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  ALL9      = {DIGITS{BCD_MAX}};

  state_t            state_q, state_n;
  logic [PW-1:0]     presc_q, presc_n;
  logic              mode_q, mode_n, done_q, done_n, busy_q;
  logic [W-1:0]      q, clamped, ld_val, reload_q;
  logic              ld, tick, all9, all0, upper_term, near_term, pend_q, reload_ok;
  logic [DIGITS-1:0] en, dterm;

`ifdef BCD_TIMER_AUTO_RELOAD_EN
  logic         pend_n;
  logic [W-1:0] reload_n;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q   <= 1'b0;
      reload_q <= '0;
    end else begin
      pend_q   <= pend_n;
      reload_q <= reload_n;
    end
  end

  // A reload equal to the terminal value would spin forever, so it stops in DONE instead.
  assign reload_ok = mode_q ? (reload_q != ALL9) : (reload_q != '0);
`else
  assign pend_q    = 1'b0;
  assign reload_q  = '0;
  assign reload_ok = 1'b0;
`endif

  always_comb begin
    all9       = 1'b1;
    all0       = 1'b1;
    upper_term = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      clamped[4*i +: 4] = bcd_clamp(bus.load_val[4*i +: 4]);
      all9 &= (q[4*i +: 4] == BCD_MAX);
      all0 &= (q[4*i +: 4] == BCD_MIN);
      if (i > 0) upper_term &= dterm[i];
    end
  end

  // One step away from terminal: upper digits already there, digit 0 one count short.
  assign near_term = upper_term && (q[3:0] == (mode_q ? BCD_MAX - 4'd1 : BCD_MIN + 4'd1));
  assign tick      = (state_q == RUN) && !bus.clear && !bus.pause && (presc_q == PRESC_MAX);

  always_comb begin
    logic carry;
    carry = tick & ~pend_q;
    for (int i = 0; i < DIGITS; i++) begin
      en[i] = carry;
      carry = carry & dterm[i];
    end
  end

  always_comb begin
    state_n = state_q;
    presc_n = presc_q;
    mode_n  = mode_q;
    done_n  = 1'b0;
    ld      = 1'b0;
    ld_val  = clamped;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
    pend_n   = pend_q;
    reload_n = reload_q;
`endif
    if (bus.clear) begin
      state_n = IDLE;
      presc_n = '0;
      ld      = 1'b1;
      ld_val  = '0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      pend_n  = 1'b0;
`endif
    end else if (bus.load && state_q != RUN) begin
      ld      = 1'b1;
      state_n = (state_q == PAUSE) ? PAUSE : IDLE;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
      reload_n = clamped;
`endif
    end else if (bus.start && state_q != RUN) begin
      if (state_q == PAUSE) begin
        if (!pend_q && (mode_q ? all9 : all0)) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n = RUN;
        end
      end else begin
        mode_n  = bus.mode;
        presc_n = '0;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
        pend_n  = 1'b0;
`endif
        if (bus.mode ? all9 : all0) begin
          state_n = DONE;
          done_n  = 1'b1;
        end else begin
          state_n = RUN;
        end
      end
    end else if (bus.pause && state_q == RUN) begin
      state_n = PAUSE;
    end else if (state_q == RUN) begin
      presc_n = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        if (pend_q) begin
          ld     = 1'b1;
          ld_val = reload_q;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
          pend_n = 1'b0;
`endif
        end else if (near_term) begin
          done_n = 1'b1;
          if (!reload_ok) state_n = DONE;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
          if (reload_ok) pend_n = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      presc_q <= '0;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      presc_q <= presc_n;
      mode_q  <= mode_n;
      done_q  <= done_n;
      busy_q  <= (state_n == RUN);
    end
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_ld u_digit (
      .clk      (clk),
      .rstn     (rstn),
      .load     (ld),
      .load_val (ld_val[4*i +: 4]),
      .en       (en[i]),
      .up       (mode_q),
      .d        (q[4*i +: 4]),
      .term     (dterm[i])
    );
  end

  assign bus.q     = q;
  assign bus.state = state_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// tb/tb_bcd_timer_ctrl.sv - directed and randomized checks of bcd_timer_ctrl against a decimal model
module tb_bcd_timer_ctrl;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 4;
`ifdef BCD_TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bcd_timer_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_timer_ctrl #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Model: the count is a plain decimal integer 0..99; states 0=IDLE 1=RUN 2=PAUSE 3=DONE.
  int m_val, m_state, m_presc, m_reload;
  bit m_mode, m_done, m_pend;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int clamp_dec(input logic [7:0] lv);
    int hi, lo;
    hi = (lv[7:4] > 9) ? 9 : int'(lv[7:4]);
    lo = (lv[3:0] > 9) ? 9 : int'(lv[3:0]);
    return hi * 10 + lo;
  endfunction

  function automatic int term_of(input bit up);
    return up ? 99 : 0;
  endfunction

  task automatic model_reset();
    m_val = 0; m_state = 0; m_presc = 0; m_reload = 0;
    m_mode = 0; m_done = 0; m_pend = 0;
  endtask

  task automatic model_step();
    bit nd;
    nd = 0;
    if (bus.clear) begin
      m_val = 0; m_state = 0; m_presc = 0; m_pend = 0;
    end else if (bus.load && m_state != 1) begin
      m_val = clamp_dec(bus.load_val);
      m_reload = m_val;
      if (m_state != 2) m_state = 0;
    end else if (bus.start && m_state != 1) begin
      if (m_state != 2) begin
        m_mode = bus.mode; m_presc = 0; m_pend = 0;
      end
      if (!m_pend && m_val == term_of(m_mode)) begin
        m_state = 3; nd = 1;
      end else begin
        m_state = 1;
      end
    end else if (bus.pause && m_state == 1) begin
      m_state = 2;
    end else if (m_state == 1) begin
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        if (m_pend) begin
          m_val = m_reload; m_pend = 0;
        end else begin
          m_val = m_mode ? (m_val + 1) % 100 : (m_val + 99) % 100;
          if (m_val == term_of(m_mode)) begin
            nd = 1;
            if (AR && m_reload != term_of(m_mode)) m_pend = 1;
            else m_state = 3;
          end
        end
      end else begin
        m_presc++;
      end
    end
    m_done = nd;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q", 32'(bus.q), 32'(to_bcd(m_val)));
    chk("state", 32'(bus.state), 32'(m_state));
    chk("busy", 32'(bus.busy), 32'(m_state == 1));
    chk("done", 32'(bus.done), 32'(m_done));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.load = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load_val = v; bus.load = 1; cyc();
  endtask

  task automatic do_start(input bit md);
    bus.mode = md; bus.start = 1; cyc();
  endtask

  task automatic async_reset();
    #2 rstn = 0;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rstn = 1;
  endtask

  initial begin
    int budget;
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.load = 0;
    bus.load_val = '0; bus.mode = 0;
    model_reset();
    #2 rstn = 0;
    #1 check_all();
    @(negedge clk);
    rstn = 1;

    // Count down 12 -> 00, then hold in DONE.
    do_load(8'h12);
    do_start(1'b0);
    idle(12 * TICK_DIV + 6);
    chk("down_final_q", 32'(bus.q), 32'h00);
    chk("down_final_state", 32'(bus.state), 32'd3);

    // Count up 97 -> 99, mode flips mid-run are ignored.
    do_load(8'h97);
    do_start(1'b1);
    bus.mode = 0;
    idle(3 * TICK_DIV);

    // Up through a 09 -> 10 carry.
    do_load(8'h07);
    do_start(1'b1);
    idle(4 * TICK_DIV);

    // Pause mid-prescale, hold, resume.
    do_load(8'h07);
    do_start(1'b0);
    idle(2 * TICK_DIV + 2);
    bus.pause = 1; cyc();
    idle(20);
    do_start(1'b1);
    idle(3 * TICK_DIV);

    // Clamping load, and load ignored during RUN.
    bus.clear = 1; cyc();
    do_load(8'hAF);
    chk("load_clamp", 32'(bus.q), 32'h99);
    do_start(1'b0);
    idle(TICK_DIV + 1);
    do_load(8'h33);
    idle(2 * TICK_DIV);

    // Start at terminal, then clear beats load and start.
    bus.clear = 1; cyc();
    do_start(1'b0);
    chk("start_at_term_done", 32'(bus.done), 32'd1);
    idle(2);
    bus.clear = 1; bus.load = 1; bus.load_val = 8'h55; bus.start = 1; cyc();
    chk("clear_priority_q", 32'(bus.q), 32'h00);

    // Asynchronous reset while running at 07.
    do_load(8'h09);
    do_start(1'b0);
    budget = 0;
    while (m_val != 7 && budget < 100) begin cyc(); budget++; end
    chk("reach_07", 32'(budget < 100), 32'd1);
    async_reset();

`ifdef BCD_TIMER_AUTO_RELOAD_EN
    do_load(8'h02);
    do_start(1'b0);
    idle(8 * TICK_DIV);
    bus.clear = 1; cyc();
`endif

    // Randomized control pulses.
    for (int n = 0; n < 4000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      bus.mode = 1'($urandom);
      bus.load_val = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      bus.clear = (r < 2);
      bus.load  = (r >= 2 && r < 6) || (r == 99);
      bus.start = (r >= 6 && r < 13) || (r == 99);
      bus.pause = (r >= 13 && r < 17) || (r == 98);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
